axi_wr_arbiter: RTL

Round-robin arbiter that shares one single-beat AXI write slave (AW/W/B) between N_MASTERS requesters.
//   It sits in front of the register-file slave and grants one master at a time.
//   For the granted master it forwards AW and W to the slave and routes B back, then rotates priority.

---
 rtl/axi_wr_arb_pkg.sv | 20 ++
 rtl/axi_wr_arbiter_rr.sv | 32 +++
 rtl/axi_wr_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/axi_wr_arb_pkg.sv
// Shared types for the single-beat AXI write arbiter.
// Latency: none (types, constants and a width helper only).
// Backpressure: not applicable.
package axi_wr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // Width of a pointer that can index n masters; never below one bit.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_wr_arbiter_rr.sv
// Round-robin pick: the first requester strictly after ptr_i, wrapping around.
// Latency: purely combinational.
// Backpressure: none; gnt_o is all zeros when req_i is all zeros.
module rr_arbiter
  import axi_wr_arb_pkg::*;
#(
  parameter int unsigned N  = 2,
  parameter int unsigned PW = ptr_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);

  logic          found;
  logic [PW-1:0] idx;

  // Walk the masters starting one past the pointer; the first requester wins.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned off = 1; off <= N; off++) begin
      idx = PW'((32'(ptr_i) + off) % N);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Shares one single-beat AXI write slave between N_MASTERS masters, round-robin.
// Latency: 1 cycle to arbitrate, then AW/W/B pass through combinationally; min 3 cycles per write.
// Backpressure: slave ready/valid go straight to the granted master; others see ready 0 until served.
module axi_wr_arbiter
  import axi_wr_arb_pkg::*;
#(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32
) (
  input  logic                             clk,
  input  logic                             areset,
  input  logic [N_MASTERS*ADDR_W-1:0]      m_awaddr_i,
  input  logic [N_MASTERS-1:0]             m_awvalid_i,
  output logic [N_MASTERS-1:0]             m_awready_o,
  input  logic [N_MASTERS*DATA_W-1:0]      m_wdata_i,
  input  logic [N_MASTERS*(DATA_W/8)-1:0]  m_wstrb_i,
  input  logic [N_MASTERS-1:0]             m_wvalid_i,
  output logic [N_MASTERS-1:0]             m_wready_o,
  output logic [N_MASTERS*2-1:0]           m_bresp_o,
  output logic [N_MASTERS-1:0]             m_bvalid_o,
  input  logic [N_MASTERS-1:0]             m_bready_i,
  output logic [ADDR_W-1:0]                s_awaddr_o,
  output logic                             s_awvalid_o,
  input  logic                             s_awready_i,
  output logic [DATA_W-1:0]                s_wdata_o,
  output logic [DATA_W/8-1:0]              s_wstrb_o,
  output logic                             s_wlast_o,
  output logic                             s_wvalid_o,
  input  logic                             s_wready_i,
  input  logic [1:0]                       s_bresp_i,
  input  logic                             s_bvalid_i,
  output logic                             s_bready_o,
  output logic [N_MASTERS-1:0]             grant_o
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned PW     = ptr_width(N_MASTERS);

  arb_state_t           state_q, state_d;
  logic [N_MASTERS-1:0] grant_q, grant_d;
  logic [PW-1:0]        rr_q, rr_d;
  logic                 aw_done_q, aw_done_d;
  logic                 w_done_q, w_done_d;

  logic [N_MASTERS-1:0] arb_gnt;
  logic                 aw_hs;
  logic                 w_hs;
  logic                 b_hs;

  rr_arbiter #(
    .N  (N_MASTERS),
    .PW (PW)
  ) u_rr (
    .req_i (m_awvalid_i),
    .ptr_i (rr_q),
    .gnt_o (arb_gnt)
  );

  assign s_wlast_o = 1'b1;
  assign grant_o   = grant_q;

  assign aw_hs = s_awvalid_o & s_awready_i;
  assign w_hs  = s_wvalid_o & s_wready_i;
  assign b_hs  = s_bvalid_i & s_bready_o;

  // Route the granted master to the slave; AW/W are suppressed once done so a
  // master still holding valid cannot cause a second beat.
  always_comb begin
    s_awaddr_o  = '0;
    s_wdata_o   = '0;
    s_wstrb_o   = '0;
    s_awvalid_o = 1'b0;
    s_wvalid_o  = 1'b0;
    s_bready_o  = 1'b0;
    m_awready_o = '0;
    m_wready_o  = '0;
    m_bvalid_o  = '0;
    m_bresp_o   = '0;
    for (int i = 0; i < int'(N_MASTERS); i++) begin
      if (grant_q[i]) begin
        s_awaddr_o = m_awaddr_i[i*ADDR_W +: ADDR_W];
        s_wdata_o  = m_wdata_i[i*DATA_W +: DATA_W];
        s_wstrb_o  = m_wstrb_i[i*STRB_W +: STRB_W];
        if (state_q == XFER) begin
          s_awvalid_o    = m_awvalid_i[i] & ~aw_done_q;
          s_wvalid_o     = m_wvalid_i[i] & ~w_done_q;
          m_awready_o[i] = s_awready_i & ~aw_done_q;
          m_wready_o[i]  = s_wready_i & ~w_done_q;
        end
        if (state_q == RESP) begin
          s_bready_o         = m_bready_i[i];
          m_bvalid_o[i]      = s_bvalid_i;
          m_bresp_o[i*2 +: 2] = s_bresp_i;
        end
      end
    end
  end

  // Next-state logic: arbitrate in IDLE, collect AW/W in XFER, wait for B in RESP.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      IDLE: begin
        if (|m_awvalid_i) begin
          grant_d = arb_gnt;
          state_d = XFER;
        end
      end
      XFER: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d && w_done_d) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (b_hs) begin
          // The master just served becomes lowest priority next round.
          for (int i = 0; i < int'(N_MASTERS); i++) begin
            if (grant_q[i]) begin
              rr_d = PW'(i);
            end
          end
          grant_d   = '0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        grant_d   = '0;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  // State registers; reset leaves the pointer on the last master so master 0 wins first.
  always_ff @(posedge clk) begin
    if (areset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_q      <= PW'(N_MASTERS - 1);
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule
